pipe_stage_skid_reg: RTL



---
 rtl/pipe_stage_skid_reg.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register: valid/ready handshake with a registered in_ready,
// a two-entry skid buffer, synchronous flush and saturating stall/bubble counters.
module pipe_stage_skid_reg #(
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  valid_q;
  logic                  in_ready_q;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic [CNT_WIDTH-1:0]  bubble_q, bubble_d;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (CLR) begin
      // Squash: anything accepted this cycle is dropped along with held entries.
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Counters observe pre-edge handshake signals and keep counting through flushes.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (valid_q && !out_ready && stall_q != CNT_MAX) begin
      stall_d = stall_q + CNT_ONE;
    end
    if (!valid_q && out_ready && bubble_q != CNT_MAX) begin
      bubble_d = bubble_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= EMPTY;
      main_q     <= RESET_VALUE;
      skid_q     <= RESET_VALUE;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      valid_q    <= (state_d != EMPTY);
      in_ready_q <= (state_d != FULL);
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = valid_q;
  assign out_data   = main_q;
  assign occupancy  = state_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule
